bcd_add_seq: RTL and testbench

BCD_ADD_SEQ -- requirements
Module: bcd_add_seq

---
 rtl/bcd_add_seq.sv | 206 ++++++++++++++++++++
 tb/tb_bcd_add_seq.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_add_seq.sv
// bcd_add_seq: digit-serial packed-BCD adder.
// One operation takes one cycle per digit, least significant digit first,
// and all digits share a single one-digit BCD adder slice. Any non-BCD
// operand digit aborts the operation with an error result.
// Optional feature: define BCD_SUB_EN to add ten's-complement subtraction,
// which is selected by the sub input when an operation starts.
module bcd_add_seq #(
    parameter int DIGITS = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        sub,
    input  logic [4*DIGITS-1:0]         a,
    input  logic [4*DIGITS-1:0]         b,
    input  logic                        cin,
    output logic                        busy,
    output logic                        done,
    output logic [4*DIGITS-1:0]         sum,
    output logic                        cout,
    output logic                        err,
    output logic [$clog2(DIGITS)-1:0]   err_digit
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = $clog2(DIGITS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    // A digit is valid BCD when it is in the range 0 to 9.
    function automatic logic digit_valid(input logic [3:0] d);
        return (d <= 4'd9);
    endfunction

    // One-digit BCD adder slice: the result is {carry_out, digit}.
    function automatic logic [4:0] bcd_slice(input logic [3:0] x,
                                             input logic [3:0] y,
                                             input logic       c);
        logic [4:0] t;
        logic [4:0] u;
        t = {1'b0, x} + {1'b0, y} + {4'b0000, c};
        u = t - 5'd10;
        if (t > 5'd9) begin
            return {1'b1, u[3:0]};
        end else begin
            return {1'b0, t[3:0]};
        end
    endfunction

    state_t          r_state;
    state_t          w_next;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_sum;
    logic [IW-1:0]   r_idx;
    logic [IW-1:0]   r_err_digit;
    logic            r_carry;
    logic            r_cout;
    logic            r_err;
    logic            r_busy;
    logic            r_done;

    logic [3:0]      w_a_dig;
    logic [3:0]      w_b_dig;
    logic [3:0]      w_b_eff;
    logic            w_bad;
    logic            w_last;
    logic [4:0]      w_slice;
    logic            w_init_carry;

    assign w_a_dig = r_a[{r_idx, 2'b00} +: 4];
    assign w_b_dig = r_b[{r_idx, 2'b00} +: 4];
    // Validity is always judged on the operand as supplied, never on its complement.
    assign w_bad   = !digit_valid(w_a_dig) || !digit_valid(w_b_dig);
    assign w_last  = (r_idx == IW'(DIGITS - 1));
    assign w_slice = bcd_slice(w_a_dig, w_b_eff, r_carry);

`ifdef BCD_SUB_EN
    logic r_sub;

    // Subtraction adds the nine's complement of b plus one.
    assign w_b_eff      = r_sub ? (4'd9 - w_b_dig) : w_b_dig;
    assign w_init_carry = sub ? 1'b1 : cin;

    // Capture the operation select together with the operands.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sub <= 1'b0;
        end else if ((r_state == IDLE) && start) begin
            r_sub <= sub;
        end else begin
            r_sub <= r_sub;
        end
    end
`else
    logic w_unused_sub;

    // Without subtraction the select input has no function.
    assign w_unused_sub = sub;
    assign w_b_eff      = w_b_dig;
    assign w_init_carry = cin;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode: accept a start only when idle, stop early on a bad digit.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = ADD;
                end else begin
                    w_next = IDLE;
                end
            end
            ADD: begin
                if (w_bad) begin
                    w_next = ERR;
                end else if (w_last) begin
                    w_next = DONE;
                end else begin
                    w_next = ADD;
                end
            end
            DONE:    w_next = IDLE;
            ERR:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath: latch operands, step one digit per cycle, and register the results and flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_idx       <= '0;
            r_err_digit <= '0;
            r_carry     <= 1'b0;
            r_cout      <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_busy <= (w_next != IDLE);
            r_done <= (w_next == DONE) || (w_next == ERR);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_idx   <= '0;
                        r_carry <= w_init_carry;
                        r_err   <= 1'b0;
                    end
                end
                ADD: begin
                    if (w_bad) begin
                        r_err       <= 1'b1;
                        r_err_digit <= r_idx;
                        r_sum       <= {DIGITS{4'hF}};
                        r_cout      <= 1'b0;
                    end else begin
                        r_sum[{r_idx, 2'b00} +: 4] <= w_slice[3:0];
                        r_carry                    <= w_slice[4];
                        if (w_last) begin
                            r_cout <= w_slice[4];
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_carry <= r_carry;
                end
                ERR: begin
                    r_carry <= r_carry;
                end
                default: begin
                    r_carry <= r_carry;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign err       = r_err;
    assign err_digit = r_err_digit;

endmodule

// File: tb/tb_bcd_add_seq.sv
// Self-checking bench for bcd_add_seq (DIGITS = 4). A decimal-arithmetic
// model predicts every operation. Compile with BCD_SUB_EN to cover subtraction.
module tb_bcd_add_seq;

    localparam int D = 4;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sub;
    logic        cin;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        err;
    logic [1:0]  err_digit;

    int checks = 0;
    int errors = 0;

    bcd_add_seq #(.DIGITS(D)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub),
        .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout),
        .err(err), .err_digit(err_digit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic        e;
        logic [1:0]  ed;
        logic [7:0]  lat;
    } exp_t;

    // Decimal model: decode the operands to integers, do plain arithmetic, re-encode.
    function automatic exp_t model(input logic [15:0] fa, input logic [15:0] fb,
                                   input logic fc, input logic fs, input logic [1:0] hed);
        exp_t   r;
        longint va = 0;
        longint vb = 0;
        longint p  = 1;
        longint v;
        int     bad = -1;
        logic [3:0] da;
        logic [3:0] db;
        for (int i = 0; i < D; i++) begin
            da = fa[4*i +: 4];
            db = fb[4*i +: 4];
            if (bad < 0 && (da > 9 || db > 9)) bad = i;
            va += longint'(da) * p;
            vb += longint'(db) * p;
            p  *= 10;
        end
        if (bad >= 0) begin
            r.s   = 16'hFFFF;
            r.c   = 1'b0;
            r.e   = 1'b1;
            r.ed  = bad[1:0];
            r.lat = 8'(bad + 2);
            return r;
        end
        v = va + vb + longint'(fc);
`ifdef BCD_SUB_EN
        if (fs) v = va - vb + p;
`else
        if (fs) v = va + vb + longint'(fc);
`endif
        r.c   = (v >= p);
        v     = v % p;
        for (int i = 0; i < D; i++) begin
            r.s[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        r.e   = 1'b0;
        r.ed  = hed;
        r.lat = 8'(D + 1);
        return r;
    endfunction

    // Model state: m_cnt counts the remaining cycles until done (1 = done cycle).
    logic m_valid = 1'b0;
    int   m_cnt   = 0;
    exp_t m_p;
    exp_t m_h;

    // Model timeline, advanced on every rising edge.
    always @(posedge clk) begin
        m_valid <= 1'b1;
        if (!rst_n) begin
            m_cnt <= 0;
            m_h   <= '0;
            m_p   <= '0;
        end else if (m_cnt == 0 && start) begin
            m_p   <= model(a, b, cin, sub, m_h.ed);
            m_cnt <= int'(model(a, b, cin, sub, m_h.ed).lat);
            m_h.e <= 1'b0;
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 2) m_h <= m_p;
        end
    end

    // Compare process: check the DUT outputs against the model on every falling edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("busy", 32'(busy), 32'(m_cnt != 0));
            check("done", 32'(done), 32'(m_cnt == 1));
            if (m_cnt <= 1) begin
                check("sum", 32'(sum), 32'(m_h.s));
                check("cout", 32'(cout), 32'(m_h.c));
                check("err", 32'(err), 32'(m_h.e));
                check("err_digit", 32'(err_digit), 32'(m_h.ed));
            end else begin
                check("err_busy", 32'(err), 32'd0);
            end
        end
    end

    // One operation with hand-computed expectations; poke>0 re-pulses start at cycle T+poke.
    task automatic run_op(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                          input logic ic, input logic is,
                          input logic [15:0] es, input logic ec, input logic ee,
                          input logic [1:0] eed, input int elat, input int poke);
        int n;
        @(negedge clk);
        a = ia; b = ib; cin = ic; sub = is; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 16'h0000; b = 16'hFFFF; cin = ~ic; sub = ~is;
        n = 1;
        while (done !== 1'b1 && n < 20) begin
            if (n == poke) begin
                start = 1'b1; a = 16'h9999; b = 16'h9999;
            end
            @(negedge clk);
            start = 1'b0;
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(elat));
        check({tag, "_sum"}, 32'(sum), 32'(es));
        check({tag, "_cout"}, 32'(cout), 32'(ec));
        check({tag, "_err"}, 32'(err), 32'(ee));
        if (ee) check({tag, "_err_digit"}, 32'(err_digit), 32'(eed));
        check({tag, "_model_sum"}, 32'(m_h.s), 32'(es));
        check({tag, "_model_cout"}, 32'(m_h.c), 32'(ec));
        @(negedge clk);
        check({tag, "_single_done"}, 32'(done), 32'd0);
    endtask

    // Reset asserted at T+3 of an operation must abort it silently.
    task automatic reset_mid_op();
        int dcount = 0;
        @(negedge clk);
        a = 16'h1234; b = 16'h5678; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (done === 1'b1) dcount++;
        end
        check("rst_no_done", 32'(dcount), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0;
        a = 16'h0000; b = 16'h0000;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        rst_n = 1'b1;

        run_op("basic",   16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0, 2'd0, 5, 0);
        run_op("ripple",  16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 2'd0, 5, 0);
        run_op("cin",     16'h0009, 16'h0000, 1'b1, 1'b0, 16'h0010, 1'b0, 1'b0, 2'd0, 5, 0);
        run_op("err_d1",  16'h12A4, 16'h0000, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b1, 2'd1, 3, 0);
        run_op("clr_err", 16'h4321, 16'h1111, 1'b0, 1'b0, 16'h5432, 1'b0, 1'b0, 2'd0, 5, 0);
        run_op("err_b3",  16'h0000, 16'hF000, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b1, 2'd3, 5, 0);
        run_op("err_d0",  16'h000B, 16'h000C, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b1, 2'd0, 2, 0);
        run_op("full",    16'h5555, 16'h4444, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 2'd0, 5, 0);
        run_op("mid",     16'h0458, 16'h0367, 1'b0, 1'b0, 16'h0825, 1'b0, 1'b0, 2'd0, 5, 0);
        run_op("poke",    16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0, 2'd0, 5, 2);
`ifdef BCD_SUB_EN
        run_op("sub_pos", 16'h0500, 16'h0123, 1'b1, 1'b1, 16'h0377, 1'b1, 1'b0, 2'd0, 5, 0);
        run_op("sub_neg", 16'h0123, 16'h0500, 1'b0, 1'b1, 16'h9623, 1'b0, 1'b0, 2'd0, 5, 0);
        run_op("sub_eq",  16'h4444, 16'h4444, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 2'd0, 5, 0);
        run_op("sub_err", 16'h0100, 16'h00D0, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1, 2'd1, 3, 0);
`else
        run_op("sub_ign", 16'h0500, 16'h0123, 1'b0, 1'b1, 16'h0623, 1'b0, 1'b0, 2'd0, 5, 0);
        run_op("sub_ig2", 16'h0123, 16'h0500, 1'b1, 1'b1, 16'h0624, 1'b0, 1'b0, 2'd0, 5, 0);
`endif
        reset_mid_op();
        run_op("post_rst", 16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 2'd0, 5, 0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
